// File: rtl/mopshub_tb_pkg.sv
// ---------------------------------------------------------------------------
// mopshub_tb_pkg
// Shared types and helpers for the MOPSHUB bench test sequencer.
//   seq_state_t    : sequencer FSM states
//   PH_*           : phase indices (bit positions in the phase enable mask)
//   first_phase()  : lowest enabled phase of a mask (0 for an empty mask)
//   next_phase()   : next enabled phase after 'cur', with a wrap flag
// ---------------------------------------------------------------------------
package mopshub_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_RUN     = 3'd2,
    ST_ENDWAIT = 3'd3,
    ST_GAP     = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_t;

  localparam logic [1:0] PH_TRIM = 2'd0;
  localparam logic [1:0] PH_RX   = 2'd1;
  localparam logic [1:0] PH_TX   = 2'd2;
  localparam logic [1:0] PH_ADV  = 2'd3;

  typedef struct packed {
    logic       wrap;
    logic [1:0] ph;
  } next_phase_t;

  function automatic logic [1:0] first_phase(input logic [3:0] mask);
    logic [1:0] r;
    r = 2'd0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) r = 2'(i);
    end
    return r;
  endfunction

  function automatic next_phase_t next_phase(input logic [3:0] mask,
                                             input logic [1:0] cur);
    next_phase_t r;
    r.wrap = 1'b1;
    r.ph   = first_phase(mask);
    for (int i = 3; i >= 0; i--) begin
      if (mask[i] && (2'(i) > cur)) begin
        r.wrap = 1'b0;
        r.ph   = 2'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_cycle_timer.sv
// ---------------------------------------------------------------------------
// seq_cycle_timer
// 16-bit loadable down-counter shared by the RUN timeout and the GAP delay.
// Counts down once per cycle and parks at zero.
//   clk_40_m : clock
//   rst      : synchronous reset, active-low (counter -> 0)
//   load     : load 'value' this cycle (has priority over counting)
//   value    : load value
//   zero     : counter currently equals zero
// ---------------------------------------------------------------------------
module seq_cycle_timer (
  input  logic        clk_40_m,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic        zero
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                cnt_d = value;
    else if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) cnt_q <= 16'd0;
    else      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/mopshub_test_sequencer.sv
// ---------------------------------------------------------------------------
// mopshub_test_sequencer
// Steps the MOPSHUB bench test phases (trim, rx, tx, adv) over N_BUSES buses,
// with a per-phase timeout, an inter-phase gap and pass/fail accounting.
//
// Parameters: N_BUSES (1..32), PHASE_MASK (bit0 trim, bit1 rx, bit2 tx,
//   bit3 adv), GAP_CYCLES (>=1), TIMEOUT_CYCLES (1..65535).
// Ports:
//   clk_40_m, rst (sync, active-low)
//   start    : level, rising edge launches a pass
//   abort    : return to IDLE, counters kept
//   loop_en  : only with MOPSHUB_SEQ_LOOP_EN; restart from DONE without IDLE
//   trim_done/rx_end/tx_end/adv_end : phase-complete pulses
//   osc_auto_trim/test_rx/test_tx/test_advanced : phase enables (one-hot/0)
//   endwait_all : one-cycle pulse after each phase
//   bus_cnt, phase_id, seq_busy, seq_done, pass_cnt, fail_cnt, timeout_flag
// Optional feature macro: MOPSHUB_SEQ_LOOP_EN (continuous looping).
// All outputs are registered from the next-state decode.
// ---------------------------------------------------------------------------
module mopshub_test_sequencer
  import mopshub_tb_pkg::*;
#(
  parameter int         N_BUSES        = 2,
  parameter logic [3:0] PHASE_MASK     = 4'b0110,
  parameter int         GAP_CYCLES     = 120,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_40_m,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
`ifdef MOPSHUB_SEQ_LOOP_EN
  input  logic       loop_en,
`endif
  input  logic       trim_done,
  input  logic       rx_end,
  input  logic       tx_end,
  input  logic       adv_end,
  output logic       osc_auto_trim,
  output logic       test_rx,
  output logic       test_tx,
  output logic       test_advanced,
  output logic       endwait_all,
  output logic [4:0] bus_cnt,
  output logic [1:0] phase_id,
  output logic       seq_busy,
  output logic       seq_done,
  output logic [7:0] pass_cnt,
  output logic [7:0] fail_cnt,
  output logic       timeout_flag
);

  localparam logic [1:0]  FIRST_PH = first_phase(PHASE_MASK);
  localparam logic [4:0]  LAST_BUS = 5'(N_BUSES - 1);
  // The timer parks on zero for one cycle, so loading N-1 gives exactly N
  // cycles in RUN before the zero check fires.
  localparam logic [15:0] RUN_LOAD = 16'(TIMEOUT_CYCLES - 1);
  // ENDWAIT is the first idle cycle of the gap, so GAP itself lasts
  // GAP_CYCLES-1 cycles (minimum one).
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES >= 2) ? 16'(GAP_CYCLES - 2) : 16'd0;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  seq_state_t  state_q, state_d;
  logic        start_q;
  logic [4:0]  bus_q, bus_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  pass_q, pass_d;
  logic [7:0]  fail_q, fail_d;
  logic        tmo_q, tmo_d;
  logic [3:0]  en_q, en_d;
  logic        endwait_q, busy_q, done_q;

  logic        tmr_load;
  logic [15:0] tmr_val;
  logic        tmr_zero;
  logic        start_rise;
  logic [3:0]  ends;
  logic        end_hit;
  next_phase_t np;

  assign start_rise = start & ~start_q;
  assign ends       = {adv_end, tx_end, rx_end, trim_done};
  assign end_hit    = ends[phase_q];

  seq_cycle_timer u_timer (
    .clk_40_m (clk_40_m),
    .rst      (rst),
    .load     (tmr_load),
    .value    (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    bus_d    = bus_q;
    phase_d  = phase_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q;
    tmr_load = 1'b0;
    tmr_val  = 16'd0;
    np       = next_phase(PHASE_MASK, phase_q);

    if (abort) begin
      // Abort also masks a start edge arriving in IDLE.
      if (state_q != ST_IDLE) state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_rise) begin
            pass_d  = 8'd0;
            fail_d  = 8'd0;
            tmo_d   = 1'b0;
            bus_d   = 5'd0;
            phase_d = FIRST_PH;
            state_d = (PHASE_MASK == 4'd0) ? ST_DONE : ST_ARM;
          end
        end
        ST_ARM: begin
          tmr_load = 1'b1;
          tmr_val  = RUN_LOAD;
          state_d  = ST_RUN;
        end
        ST_RUN: begin
          // A completion pulse in the same cycle as the timeout is a pass.
          if (end_hit) begin
            pass_d  = sat_inc(pass_q);
            state_d = ST_ENDWAIT;
          end else if (tmr_zero) begin
            fail_d  = sat_inc(fail_q);
            tmo_d   = 1'b1;
            state_d = ST_ENDWAIT;
          end
        end
        ST_ENDWAIT: begin
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end
        ST_GAP: begin
          if (tmr_zero) state_d = ST_NEXT;
        end
        ST_NEXT: begin
          phase_d = np.ph;
          state_d = ST_ARM;
          if (np.wrap) begin
            // The last bus number is held through DONE.
            if (bus_q == LAST_BUS) state_d = ST_DONE;
            else                   bus_d   = bus_q + 5'd1;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
`ifdef MOPSHUB_SEQ_LOOP_EN
          if (loop_en && (PHASE_MASK != 4'd0)) begin
            bus_d   = 5'd0;
            phase_d = FIRST_PH;
            state_d = ST_ARM;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end

    en_d = (state_d == ST_RUN) ? (4'b0001 << phase_d) : 4'b0000;
  end

  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      start_q   <= 1'b0;
      bus_q     <= 5'd0;
      phase_q   <= 2'd0;
      pass_q    <= 8'd0;
      fail_q    <= 8'd0;
      tmo_q     <= 1'b0;
      en_q      <= 4'b0000;
      endwait_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      bus_q     <= bus_d;
      phase_q   <= phase_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      en_q      <= en_d;
      endwait_q <= (state_d == ST_ENDWAIT);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign osc_auto_trim = en_q[PH_TRIM];
  assign test_rx       = en_q[PH_RX];
  assign test_tx       = en_q[PH_TX];
  assign test_advanced = en_q[PH_ADV];
  assign endwait_all   = endwait_q;
  assign bus_cnt       = bus_q;
  assign phase_id      = phase_q;
  assign seq_busy      = busy_q;
  assign seq_done      = done_q;
  assign pass_cnt      = pass_q;
  assign fail_cnt      = fail_q;
  assign timeout_flag  = tmo_q;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
`timescale 1ns/1ps
module tb_mopshub_test_sequencer;

  logic clk_40_m = 1'b0;
  always #12.5 clk_40_m = ~clk_40_m;

  logic rst;

  // DUT A: two buses, rx+tx. DUT B: three buses, trim+adv.
  logic       start_a, abort_a, trim_a, rx_a, tx_a, adv_a;
  logic       start_b, abort_b, trim_b, rx_b, tx_b, adv_b;
  logic       loop_en_a, loop_en_b;
  logic [3:0] en_a, en_b;
  logic       ew_a, ew_b, busy_a, busy_b, done_a, done_b, tmo_a, tmo_b;
  logic [4:0] bus_a, bus_b;
  logic [1:0] ph_a, ph_b;
  logic [7:0] pass_a, pass_b, fail_a, fail_b;

  mopshub_test_sequencer #(
    .N_BUSES(2), .PHASE_MASK(4'b0110), .GAP_CYCLES(10), .TIMEOUT_CYCLES(100)
  ) dut_a (
    .clk_40_m(clk_40_m), .rst(rst), .start(start_a), .abort(abort_a),
`ifdef MOPSHUB_SEQ_LOOP_EN
    .loop_en(loop_en_a),
`endif
    .trim_done(trim_a), .rx_end(rx_a), .tx_end(tx_a), .adv_end(adv_a),
    .osc_auto_trim(en_a[0]), .test_rx(en_a[1]), .test_tx(en_a[2]), .test_advanced(en_a[3]),
    .endwait_all(ew_a), .bus_cnt(bus_a), .phase_id(ph_a), .seq_busy(busy_a),
    .seq_done(done_a), .pass_cnt(pass_a), .fail_cnt(fail_a), .timeout_flag(tmo_a)
  );

  mopshub_test_sequencer #(
    .N_BUSES(3), .PHASE_MASK(4'b1001), .GAP_CYCLES(10), .TIMEOUT_CYCLES(100)
  ) dut_b (
    .clk_40_m(clk_40_m), .rst(rst), .start(start_b), .abort(abort_b),
`ifdef MOPSHUB_SEQ_LOOP_EN
    .loop_en(loop_en_b),
`endif
    .trim_done(trim_b), .rx_end(rx_b), .tx_end(tx_b), .adv_end(adv_b),
    .osc_auto_trim(en_b[0]), .test_rx(en_b[1]), .test_tx(en_b[2]), .test_advanced(en_b[3]),
    .endwait_all(ew_b), .bus_cnt(bus_b), .phase_id(ph_b), .seq_busy(busy_b),
    .seq_done(done_b), .pass_cnt(pass_b), .fail_cnt(fail_b), .timeout_flag(tmo_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int ew_cnt_b = 0;

  always @(negedge clk_40_m) if (ew_b === 1'b1) ew_cnt_b++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_40_m);
  endtask

  function automatic logic [1:0] oh_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic set_ends(input bit b, input logic [3:0] v);
    if (b) {adv_b, tx_b, rx_b, trim_b} = v;
    else   {adv_a, tx_a, rx_a, trim_a} = v;
  endtask

  // Waits (bounded) for any enable of the selected DUT; n = ticks waited.
  task automatic wait_en(input bit b, input int max_cyc, output int n, output logic [3:0] seen);
    n = 0;
    seen = 4'b0000;
    while ((n < max_cyc) && (seen == 4'b0000)) begin
      tick();
      n++;
      seen = b ? en_b : en_a;
    end
  endtask

  task automatic wait_done(input bit b, input int max_cyc, output int n);
    logic d;
    n = 0;
    d = 1'b0;
    while ((n < max_cyc) && !d) begin
      tick();
      n++;
      d = b ? done_b : done_a;
    end
    chk("done_seen", d, 1);
  endtask

  // One phase: wait for its enable, fire a decoy end pulse of another phase,
  // then the matching end pulse after 'resp' cycles (resp<0: never -> timeout).
  // Returns one cycle after the endwait_all pulse.
  task automatic do_phase(input bit b, input string tag, input logic [3:0] exp_en,
                          input logic [4:0] exp_bus, input int exp_wait, input int resp);
    int n;
    logic [3:0] seen, decoy;
    decoy = b ? 4'b0100 : {exp_en[2:0], exp_en[3]};
    wait_en(b, 200, n, seen);
    chk({tag, "_wait"}, n, exp_wait);
    chk({tag, "_en"}, seen, exp_en);
    chk({tag, "_bus"}, b ? bus_b : bus_a, exp_bus);
    chk({tag, "_ph"}, b ? ph_b : ph_a, oh_idx(exp_en));
    if (resp < 0) begin
      repeat (10) tick();
      set_ends(b, decoy);
      tick();
      set_ends(b, 4'b0000);
      repeat (88) tick();
      chk({tag, "_last_run"}, b ? en_b : en_a, exp_en);
      tick();
      chk({tag, "_tmo"}, b ? tmo_b : tmo_a, 1);
    end else begin
      repeat (resp / 2) tick();
      set_ends(b, decoy);
      tick();
      set_ends(b, 4'b0000);
      repeat (resp - resp / 2 - 1) tick();
      chk({tag, "_decoy_ign"}, b ? en_b : en_a, exp_en);
      set_ends(b, exp_en);
      tick();
      set_ends(b, 4'b0000);
    end
    chk({tag, "_off"}, b ? en_b : en_a, 0);
    chk({tag, "_ew"}, b ? ew_b : ew_a, 1);
    tick();
    chk({tag, "_ew_end"}, b ? ew_b : ew_a, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    logic [3:0] seen;
    rst = 1'b0;
    {start_a, abort_a, trim_a, rx_a, tx_a, adv_a, loop_en_a} = '0;
    {start_b, abort_b, trim_b, rx_b, tx_b, adv_b, loop_en_b} = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_en", en_a, 0);
    chk("rst_ew", ew_a, 0);
    chk("rst_bus", bus_a, 0);
    chk("rst_ph", ph_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cnt", {pass_a, fail_a}, 0);
    chk("rst_tmo", tmo_a, 0);
    rst = 1'b1;
    tick();

    // T1: rx,tx on bus 0 then bus 1, all answered after 50 cycles
    start_a = 1'b1;
    do_phase(0, "t1p0", 4'b0010, 5'd0, 2, 50);
    chk("t1p0_pass", pass_a, 1);
    start_a = 1'b0; tick(); start_a = 1'b1; tick(); start_a = 1'b0;  // ignored while busy
    do_phase(0, "t1p1", 4'b0100, 5'd0, 9, 50);
    chk("t1p1_pass", pass_a, 2);
    do_phase(0, "t1p2", 4'b0010, 5'd1, 11, 50);
    do_phase(0, "t1p3", 4'b0100, 5'd1, 11, 50);
    wait_done(0, 50, n);
    chk("t1_done_lat", n, 10);
    chk("t1_pass", pass_a, 4);
    chk("t1_fail", fail_a, 0);
    chk("t1_tmo", tmo_a, 0);
    chk("t1_bus", bus_a, 1);
    tick();
    chk("t1_done_pulse", done_a, 0);
    chk("t1_idle", busy_a, 0);

    // T2: tx never answers -> timeout after 100 cycles
    start_a = 1'b1;
    do_phase(0, "t2p0", 4'b0010, 5'd0, 2, 50);
    chk("t2_cleared", {pass_a, fail_a}, {8'd1, 8'd0});
    start_a = 1'b0;
    do_phase(0, "t2p1", 4'b0100, 5'd0, 11, -1);
    do_phase(0, "t2p2", 4'b0010, 5'd1, 11, 50);
    do_phase(0, "t2p3", 4'b0100, 5'd1, 11, -1);
    wait_done(0, 50, n);
    chk("t2_done_lat", n, 10);
    chk("t2_pass", pass_a, 2);
    chk("t2_fail", fail_a, 2);
    chk("t2_tmo", tmo_a, 1);
    tick();

    // T3: end pulse on the timeout cycle, then abort in GAP and in RUN
    start_a = 1'b1;
    tick();
    chk("t3_clr", {pass_a, fail_a, 7'd0, tmo_a}, 0);
    start_a = 1'b0;
    do_phase(0, "t3p0", 4'b0010, 5'd0, 1, 99);
    chk("t3_tie_pass", pass_a, 1);
    chk("t3_tie_fail", fail_a, 0);
    chk("t3_tie_tmo", tmo_a, 0);
    repeat (3) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("t3_ab_en", en_a, 0);
    chk("t3_ab_busy", busy_a, 0);
    chk("t3_ab_ew", ew_a, 0);
    chk("t3_ab_pass", pass_a, 1);
    start_a = 1'b1;
    wait_en(0, 10, n, seen);
    chk("t3_restart_en", seen, 4'b0010);
    chk("t3_restart_clr", pass_a, 0);
    abort_a = 1'b1;
    start_a = 1'b0;
    tick();
    abort_a = 1'b0;
    chk("t3_abrun_en", en_a, 0);
    chk("t3_abrun_busy", busy_a, 0);

    // T4: mask 1001 over three buses, tx_end decoys ignored
    base = ew_cnt_b;
    start_b = 1'b1;
    do_phase(1, "t4p0", 4'b0001, 5'd0, 2, 10);
    start_b = 1'b0;
    do_phase(1, "t4p1", 4'b1000, 5'd0, 11, 10);
    do_phase(1, "t4p2", 4'b0001, 5'd1, 11, 10);
    do_phase(1, "t4p3", 4'b1000, 5'd1, 11, 10);
    do_phase(1, "t4p4", 4'b0001, 5'd2, 11, 10);
    do_phase(1, "t4p5", 4'b1000, 5'd2, 11, 10);
    wait_done(1, 50, n);
    chk("t4_done_lat", n, 10);
    chk("t4_ew_count", ew_cnt_b - base, 6);
    chk("t4_pass", pass_b, 6);
    chk("t4_fail", fail_b, 0);
    chk("t4_bus", bus_b, 2);
    tick();

`ifdef MOPSHUB_SEQ_LOOP_EN
    // T5: looping pass restarts from DONE without visiting IDLE
    loop_en_a = 1'b1;
    start_a = 1'b1;
    do_phase(0, "t5p0", 4'b0010, 5'd0, 2, 10);
    start_a = 1'b0;
    do_phase(0, "t5p1", 4'b0100, 5'd0, 11, 10);
    do_phase(0, "t5p2", 4'b0010, 5'd1, 11, 10);
    do_phase(0, "t5p3", 4'b0100, 5'd1, 11, 10);
    wait_done(0, 50, n);
    chk("t5_done1_lat", n, 10);
    chk("t5_done1_bus", bus_a, 1);
    tick();
    chk("t5_loop_busy", busy_a, 1);
    chk("t5_loop_bus", bus_a, 0);
    chk("t5_loop_ph", ph_a, 1);
    do_phase(0, "t5p4", 4'b0010, 5'd0, 1, 10);
    do_phase(0, "t5p5", 4'b0100, 5'd0, 11, 10);
    do_phase(0, "t5p6", 4'b0010, 5'd1, 11, 10);
    do_phase(0, "t5p7", 4'b0100, 5'd1, 11, 10);
    wait_done(0, 50, n);
    chk("t5_done2_lat", n, 10);
    chk("t5_pass", pass_a, 8);
    loop_en_a = 1'b0;
    tick();
    chk("t5_idle", busy_a, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mopshub_test_sequencer.md
# mopshub_test_sequencer

Parametrised, synthesisable sequencer that drives the MOPSHUB bench test phases (oscillator trim, RX, TX, custom message) across N buses. It iterates every enabled phase for every bus, with a per-phase timeout, an inter-phase gap and pass/fail accounting. It sits beside `data_generator` on the master clock domain and replaces hand-written `always` stimulus sequencing.

## Interface
- `N_BUSES`, 2: buses to iterate, 1..32.
- `PHASE_MASK`, 4'b0110: phase enables; bit0 trim, bit1 rx, bit2 tx, bit3 adv.
- `GAP_CYCLES`, 120: idle cycles between phases (3 µs at 40 MHz), ≥1.
- `TIMEOUT_CYCLES`, 65535: maximum cycles in RUN, ≥1, fits 16 bits.
- `clk_40_m`  in  1  sequencer clock.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  level; a rising edge (sampled) launches a pass (sign_on_sig).
- `abort`  in  1  synchronous abort; highest priority after reset.
- `trim_done`, `rx_end`, `tx_end`, `adv_end`  in  1 each  phase-complete pulses.
- `osc_auto_trim`, `test_rx`, `test_tx`, `test_advanced`  out  1 each  phase enables, one-hot or all zero.
- `endwait_all`  out  1  one-cycle pulse after each phase ends.
- `bus_cnt`  out  5  bus under test, 0..N_BUSES-1.
- `phase_id`  out  2  current phase index.
- `seq_busy`  out  1  high outside IDLE.
- `seq_done`  out  1  one-cycle pulse at end of pass.
- `pass_cnt`, `fail_cnt`  out  8 each  phase outcomes, saturate at 255.
- `timeout_flag`  out  1  sticky; set on any timeout, cleared on next start.

## Operation
- States: IDLE, ARM, RUN, ENDWAIT, GAP, NEXT, DONE.
- IDLE: start edge → clear counters and timeout_flag; bus_cnt=0; phase_id=lowest set bit of PHASE_MASK; → ARM. PHASE_MASK=0 → DONE directly.
- ARM: assert enable of phase_id; load timer with TIMEOUT_CYCLES; → RUN.
- RUN: the end pulse matching phase_id → pass_cnt+1, → ENDWAIT. Timer reaching 0 → fail_cnt+1, timeout_flag=1, → ENDWAIT. If both occur in the same cycle, the pulse wins (pass). End pulses for other phases are ignored.
- ENDWAIT: phase enable low; endwait_all=1 for exactly this cycle; load timer with GAP_CYCLES; → GAP.
- GAP: count down to 0 → NEXT.
- NEXT: advance to the next set bit of PHASE_MASK. If no set bit remains, bus_cnt+1 and phase_id wraps to the lowest set bit. If bus_cnt was N_BUSES-1 → DONE, else → ARM.
- DONE: seq_done=1 for one cycle → IDLE. bus_cnt holds its last value.
- abort in any non-IDLE state: next cycle all enables low, endwait_all=0, → IDLE; counters keep their values.
- A start edge while busy is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, timer 0.
- All outputs are registered.
- start edge at cycle t → phase enable high at t+2 (IDLE→ARM, ARM drives the enable).
- end pulse at cycle t → enable low at t+1, endwait_all high at t+1 only.
- Next phase enable rises at t+1+GAP_CYCLES+2.
- A timeout asserts after exactly TIMEOUT_CYCLES cycles in RUN.
- Reset mid-operation takes effect on the next edge and overrides abort.

## Configuration
- `MOPSHUB_SEQ_LOOP_EN` defined:
  - adds input `loop_en` (1 bit).
  - In DONE with loop_en=1: clear bus_cnt and phase_id, pulse seq_done, → ARM without returning to IDLE. Counters keep accumulating.
- Undefined: no port; single pass per start edge.

## Structure
- Shared package `mopshub_tb_pkg`:
  - `seq_state_t` enum.
  - `PH_TRIM`=0, `PH_RX`=1, `PH_TX`=2, `PH_ADV`=3.
  - function `next_phase(mask, cur)` returning the next set bit and a wrap flag.
- One sub-module, `seq_cycle_timer`: 16-bit loadable down-counter with `load`, `value`, `zero`, shared by the timeout and the gap.

## Test plan
- N_BUSES=2, mask 0110, rx_end/tx_end 50 cycles after each enable:
  - sequence rx,tx on bus 0 then bus 1;
  - pass_cnt=4, fail_cnt=0;
  - seq_done after the 4th GAP.
- TIMEOUT_CYCLES=100, tx_end never arrives → each tx phase ends at cycle 100; fail_cnt=2, timeout_flag=1.
- rx_end in the same cycle the timer hits 0 → counted as pass; fail_cnt unchanged.
- abort in GAP of bus 0 → all enables 0 next cycle, state IDLE, pass_cnt retained. A new start clears the counters.
- mask 1001, N_BUSES=3 → phase order trim,adv on buses 0..2; 6 endwait_all pulses; tx_end pulses ignored.
- With MOPSHUB_SEQ_LOOP_EN and loop_en=1 → bus_cnt wraps 1→0 with no IDLE visit; second seq_done seen.
